// File: rtl/seq_ripple_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock,
// LSB slice first, with valid/ready handshakes on both sides.
module seq_ripple_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int STEPS = (DIGIT > 0) ? WIDTH / DIGIT : 1;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   generate
      if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("seq_ripple_adder: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    step;

   logic [DIGIT:0]   slice;
   logic             msb_carry;
   logic [WIDTH-1:0] sum_next;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // The carry into the top bit of a slice is recovered from that bit's own sum.
   always_comb begin
      slice     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      msb_carry = slice[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
      sum_next  = sum;
      sum_next[int'(step)*DIGIT +: DIGIT] = slice[DIGIT-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         step  <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b ^ {WIDTH{sub}};
                  carry <= sub | cin;
                  step  <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum   <= sum_next;
               carry <= slice[DIGIT];
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               step  <= step + 1'b1;
               if (step == LAST) begin
                  cout  <= slice[DIGIT];
                  ovf   <= msb_carry ^ slice[DIGIT];
                  zero  <= (sum_next == '0);
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_ripple_adder.sv
// Directed bench for seq_ripple_adder: 16/4 vector table, backpressure, mid-op reset,
// and an exhaustive WIDTH=4 sweep over DIGIT 1, 2 and 4.
module tb_seq_ripple_adder;

   localparam int W     = 16;
   localparam int D     = 4;
   localparam int STEPS = W / D;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cin = 1'b0;
   logic          sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;
   logic          zero;

   logic [3:0]      sw_a = '0;
   logic [3:0]      sw_b = '0;
   logic            sw_cin = 1'b0;
   logic            sw_sub = 1'b0;
   logic            sw_in_valid = 1'b0;
   logic            sw_out_ready = 1'b0;
   logic [2:0]      sw_in_ready;
   logic [2:0]      sw_out_valid;
   logic [2:0]      sw_cout;
   logic [2:0]      sw_ovf;
   logic [2:0]      sw_zero;
   logic [2:0][3:0] sw_sum;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_ripple_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   for (genvar g = 0; g < 3; g++) begin : g_sweep
      seq_ripple_adder #(.WIDTH(4), .DIGIT(1 << g)) u_sw (
         .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[g]),
         .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
         .out_valid(sw_out_valid[g]), .out_ready(sw_out_ready),
         .sum(sw_sum[g]), .cout(sw_cout[g]), .ovf(sw_ovf[g]), .zero(sw_zero[g])
      );
   end

   typedef struct {
      string        name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } vec_t;

   vec_t vecs[8];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Presents one operation and returns the number of edges until out_valid rises.
   task automatic apply_stimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vcin, input logic vsub, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check_output("in_ready_before_accept", 32'(in_ready), 32'(1));
      a        = va;
      b        = vb;
      cin      = vcin;
      sub      = vsub;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] es, input logic ec,
                               input logic eo, input logic ez);
      check_output({tag, "_out_valid"}, 32'(out_valid), 32'(1));
      check_output({tag, "_sum"}, 32'(sum), 32'(es));
      check_output({tag, "_cout"}, 32'(cout), 32'(ec));
      check_output({tag, "_ovf"}, 32'(ovf), 32'(eo));
      check_output({tag, "_zero"}, 32'(zero), 32'(ez));
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int sw_lat[3];
      logic [3:0] bb;
      logic       ci;
      logic [4:0] full;
      logic       eovf;

      vecs[0] = '{"add_basic",   16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{"add_wrap",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{"sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{"sub_neg",     16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{"add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{"add_carry",   16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{"sub_zero",    16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{"sub_cin_ign", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_output("reset_in_ready", 32'(in_ready), 32'(1));
      check_output("reset_out_valid", 32'(out_valid), 32'(0));
      check_output("reset_sum", 32'(sum), 32'(0));
      check_output("reset_zero", 32'(zero), 32'(1));
      check_output("reset_cout", 32'(cout), 32'(0));
      check_output("reset_ovf", 32'(ovf), 32'(0));

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
         check_output({vecs[i].name, "_latency"}, 32'(lat), 32'(STEPS));
         check_result(vecs[i].name, vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero);
         release_result();
         check_output({vecs[i].name, "_released"}, 32'(out_valid), 32'(0));
      end

      // Backpressure: result must hold while a stray request is presented.
      apply_stimulus(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
      check_output("bp_latency", 32'(lat), 32'(STEPS));
      a        = 16'hFFFF;
      b        = 16'hFFFF;
      in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check_result("bp_hold", 16'h2345, 1'b0, 1'b0, 1'b0);
         check_output("bp_in_ready", 32'(in_ready), 32'(0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_output("bp_handoff_out_valid", 32'(out_valid), 32'(0));
      check_output("bp_handoff_no_accept", 32'(in_ready), 32'(1));
      check_output("bp_handoff_sum_kept", 32'(sum), 32'(16'h2345));
      in_valid = 1'b0;
      apply_stimulus(16'h0003, 16'h0005, 1'b0, 1'b1, lat);
      check_output("bp_next_latency", 32'(lat), 32'(STEPS));
      check_result("bp_next", 16'hFFFE, 1'b0, 1'b0, 1'b0);
      release_result();

      // Reset lands on the second RUN edge of 00FF + 0001.
      a        = 16'h00FF;
      b        = 16'h0001;
      cin      = 1'b0;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_output("midrst_in_ready", 32'(in_ready), 32'(1));
      check_output("midrst_out_valid", 32'(out_valid), 32'(0));
      check_output("midrst_sum", 32'(sum), 32'(0));
      check_output("midrst_zero", 32'(zero), 32'(1));
      apply_stimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
      check_output("midrst_fresh_latency", 32'(lat), 32'(STEPS));
      check_result("midrst_fresh", 16'h0100, 1'b0, 1'b0, 1'b0);
      release_result();

      // Exhaustive WIDTH=4 sweep; mode 0/1 = add with cin 0/1, mode 2 = sub with cin=1.
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int m = 0; m < 3; m++) begin
               sw_a        = 4'(ai);
               sw_b        = 4'(bi);
               sw_cin      = (m != 0);
               sw_sub      = (m == 2);
               sw_in_valid = 1'b1;
               @(posedge clk); #1;
               sw_in_valid = 1'b0;
               for (int g = 0; g < 3; g++) sw_lat[g] = 0;
               for (int k = 1; k <= 6; k++) begin
                  @(posedge clk); #1;
                  for (int g = 0; g < 3; g++) begin
                     if (sw_lat[g] == 0 && sw_out_valid[g]) sw_lat[g] = k;
                  end
               end
               bb   = sw_sub ? ~sw_b : sw_b;
               ci   = sw_sub ? 1'b1 : sw_cin;
               full = {1'b0, sw_a} + {1'b0, bb} + {4'b0, ci};
               eovf = (sw_a[3] == bb[3]) && (full[3] != sw_a[3]);
               for (int g = 0; g < 3; g++) begin
                  check_output($sformatf("sw_d%0d_latency", 1 << g), 32'(sw_lat[g]), 32'(4 >> g));
                  check_output($sformatf("sw_d%0d_sum a=%0h b=%0h m=%0d", 1 << g, ai, bi, m),
                               32'(sw_sum[g]), 32'(full[3:0]));
                  check_output($sformatf("sw_d%0d_cout a=%0h b=%0h m=%0d", 1 << g, ai, bi, m),
                               32'(sw_cout[g]), 32'(full[4]));
                  check_output($sformatf("sw_d%0d_ovf a=%0h b=%0h m=%0d", 1 << g, ai, bi, m),
                               32'(sw_ovf[g]), 32'(eovf));
                  check_output($sformatf("sw_d%0d_zero a=%0h b=%0h m=%0d", 1 << g, ai, bi, m),
                               32'(sw_zero[g]), 32'(full[3:0] == 4'd0));
               end
               sw_out_ready = 1'b1;
               @(posedge clk); #1;
               sw_out_ready = 1'b0;
               check_output("sw_released", 32'(sw_out_valid), 32'(0));
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
